// File: rtl/sync_fifo_ff.sv
// Single-clock FIFO of arbitrary depth with fill count, almost-full/almost-empty
// flags, sticky overflow/underflow flags and either show-ahead or registered read.
module sync_fifo_ff #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_LVL   = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_LVL   = CNT_WIDTH'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode only the registered count, so winc/rinc never reach them combinationally.
  assign wfull         = (count_q == CNT_FULL);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AF_LVL);
  assign ralmost_empty = (count_q <= AE_LVL);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata  = mem[rptr];
    assign rvalid = ~rempty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) begin
          rdata_q <= mem[rptr];
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule
